// File: rtl/pixel_rect_fill_pkg.sv
// Shared types and constants for the rectangle-fill engine: FSM state
// encoding, control register map, field positions and small pack/unpack
// helpers for the corner registers and the CMD status word.
package pixel_fill_pkg;

    // Default geometry of the visible frame and the XY address layout
    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;
    localparam int DEF_Y_SHIFT  = 10;

    // Width of one pixel coordinate held in P0/P1
    localparam int COORD_W = 9;

    // Engine states; CLIP is a single cycle between the start strobe and the first write
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLIP  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Control slave word addresses
    localparam logic [1:0] REG_BASE = 2'd0;
    localparam logic [1:0] REG_P0   = 2'd1;
    localparam logic [1:0] REG_P1   = 2'd2;
    localparam logic [1:0] REG_CMD  = 2'd3;

    // P0/P1 layout: {y[24:16], x[8:0]}
    localparam int P_X_LSB = 0;
    localparam int P_Y_LSB = 16;

    // CMD write layout: {irq_en[31], colour[15:0]}
    localparam int CMD_COLOUR_LSB = 0;
    localparam int CMD_IRQ_EN_BIT = 31;

    // CMD read layout: {colour[31:16], 13'b0, irq_en[2], done[1], busy[0]}
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;
    localparam int STAT_IRQ_EN_BIT = 2;
    localparam int STAT_COLOUR_LSB = 16;

    // One rectangle corner
    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } point_t;

    // Extract a corner from a control write word; unused bits are discarded
    function automatic point_t unpack_point(input logic [31:0] word);
        point_t p;
        p.x = word[P_X_LSB +: COORD_W];
        p.y = word[P_Y_LSB +: COORD_W];
        return p;
    endfunction

    // Rebuild the read-back word of a corner register, unused bits read as zero
    function automatic logic [31:0] pack_point(input point_t p);
        logic [31:0] word;
        word = '0;
        word[P_X_LSB +: COORD_W] = p.x;
        word[P_Y_LSB +: COORD_W] = p.y;
        return word;
    endfunction

    // Assemble the CMD read-back status word
    function automatic logic [31:0] pack_status(input logic [15:0] colour,
                                                input logic        irq_en,
                                                input logic        done,
                                                input logic        busy);
        logic [31:0] word;
        word = '0;
        word[STAT_COLOUR_LSB +: 16] = colour;
        word[STAT_IRQ_EN_BIT]       = irq_en;
        word[STAT_DONE_BIT]         = done;
        word[STAT_BUSY_BIT]         = busy;
        return word;
    endfunction

endpackage

// File: rtl/pixel_rect_fill_if.sv
// Bus bundle of the rectangle-fill engine: the 4-word Avalon-MM control
// slave, the 16-bit Avalon-MM write master and the interrupt line.
//
// Handshake: the fill master presents fill_master_write with a stable
// address/writedata; a pixel is transferred on every rising edge where
// fill_master_write=1 and fill_master_waitrequest=0. While waitrequest=1 the
// master holds write, address and writedata unchanged. The control slave has
// no wait states: a ctrl_write is taken on the edge it is sampled, and a
// ctrl_read returns ctrl_readdata registered one cycle later.
interface pixel_rect_fill_if;

    logic [1:0]  ctrl_address;
    logic        ctrl_read;
    logic        ctrl_write;
    logic [31:0] ctrl_writedata;
    logic [31:0] ctrl_readdata;

    logic [31:0] fill_master_address;
    logic        fill_master_write;
    logic [15:0] fill_master_writedata;
    logic        fill_master_waitrequest;

    logic        irq;

    // Engine side: control slave plus pixel write master
    modport slave (
        input  ctrl_address,
        input  ctrl_read,
        input  ctrl_write,
        input  ctrl_writedata,
        output ctrl_readdata,
        output fill_master_address,
        output fill_master_write,
        output fill_master_writedata,
        input  fill_master_waitrequest,
        output irq
    );

    // System side: CPU driving the control slave, memory answering the master
    modport master (
        output ctrl_address,
        output ctrl_read,
        output ctrl_write,
        output ctrl_writedata,
        input  ctrl_readdata,
        input  fill_master_address,
        input  fill_master_write,
        input  fill_master_writedata,
        output fill_master_waitrequest,
        input  irq
    );

endinterface

// File: rtl/pixel_rect_fill.sv
// Rectangle-fill engine. Software programs BASE, two corners and a colour;
// a CMD write starts a fill that clips the far corner to the screen, then
// walks the rectangle row-major issuing one RGB565 write per pixel.
module pixel_rect_fill
    import pixel_fill_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int Y_SHIFT  = DEF_Y_SHIFT
) (
    input  logic                    clk,
    input  logic                    reset,
    pixel_rect_fill_if.slave        bus,
    output state_t                  o_dbg_state
);

    // Largest legal coordinates; the far corner is clamped to these
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

    // Programmable registers and status
    logic [31:0]        r_base;
    point_t             r_p0;
    point_t             r_p1;
    logic [15:0]        r_colour;
    logic               r_irq_en;
    logic               r_done;
    logic [31:0]        r_readdata;

    // FSM and pixel walker
    state_t             r_state;
    state_t             w_next_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    // Registered master outputs
    logic [31:0]        r_addr;
    logic               r_write;
    logic [15:0]        r_wdata;

    // Decoded control accesses
    logic               w_busy;
    logic               w_reg_wr_en;
    logic               w_cmd_start;
    logic [31:0]        w_rd_mux;

    // Clipping and walk control
    logic [COORD_W-1:0] w_x1c;
    logic [COORD_W-1:0] w_y1c;
    logic               w_reject;
    logic               w_accept;
    logic               w_row_end;
    logic               w_last;
    logic               w_load_first;
    logic               w_step;
    logic               w_finish;
    logic [COORD_W-1:0] w_next_x;
    logic [COORD_W-1:0] w_next_y;
    logic [31:0]        w_next_addr;

    assign w_busy      = (r_state != IDLE);
    // Register writes only land while idle; writes during a fill are dropped
    assign w_reg_wr_en = bus.ctrl_write && !w_busy;
    assign w_cmd_start = w_reg_wr_en && (bus.ctrl_address == REG_CMD);

    // Far corner clipped to the screen; the near corner is taken as is
    assign w_x1c    = (r_p1.x > X_MAX) ? X_MAX : r_p1.x;
    assign w_y1c    = (r_p1.y > Y_MAX) ? Y_MAX : r_p1.y;
    assign w_reject = (r_p0.x > w_x1c) || (r_p0.y > w_y1c);

    // A pixel is consumed when the write is presented and not stalled
    assign w_accept  = (r_state == WRITE) && !bus.fill_master_waitrequest;
    assign w_row_end = (r_x == w_x1c);
    assign w_last    = w_row_end && (r_y == w_y1c);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_cmd_start) w_next_state = CLIP;
            CLIP:    w_next_state = w_reject ? IDLE : WRITE;
            WRITE:   if (w_accept && w_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: walker step decisions and the next pixel coordinate
    always_comb begin
        w_load_first = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_next_x     = r_x;
        w_next_y     = r_y;
        case (r_state)
            CLIP: begin
                if (w_reject) begin
                    w_finish = 1'b1;
                end else begin
                    w_load_first = 1'b1;
                    w_step       = 1'b1;
                    w_next_x     = r_p0.x;
                    w_next_y     = r_p0.y;
                end
            end
            WRITE: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_finish = 1'b1;
                    end else if (w_row_end) begin
                        w_step   = 1'b1;
                        w_next_x = r_p0.x;
                        w_next_y = r_y + 9'd1;
                    end else begin
                        w_step   = 1'b1;
                        w_next_x = r_x + 9'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // XY byte address of the next pixel; wraps modulo 2^32
    assign w_next_addr = r_base
                       + (32'(w_next_y) << Y_SHIFT)
                       + (32'(w_next_x) << 1);

    // Control register file; BASE is kept halfword aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base   <= '0;
            r_p0     <= '0;
            r_p1     <= '0;
            r_colour <= '0;
            r_irq_en <= 1'b0;
        end else if (w_reg_wr_en) begin
            case (bus.ctrl_address)
                REG_BASE: r_base <= {bus.ctrl_writedata[31:1], 1'b0};
                REG_P0:   r_p0   <= unpack_point(bus.ctrl_writedata);
                REG_P1:   r_p1   <= unpack_point(bus.ctrl_writedata);
                REG_CMD: begin
                    r_colour <= bus.ctrl_writedata[CMD_COLOUR_LSB +: 16];
                    r_irq_en <= bus.ctrl_writedata[CMD_IRQ_EN_BIT];
                end
                default: ;
            endcase
        end
    end

    // Sticky done: cleared by an accepted start, set when a fill ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_cmd_start) begin
            r_done <= 1'b0;
        end else if (w_finish) begin
            r_done <= 1'b1;
        end
    end

    // Pixel walker and registered master outputs, held while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            if (w_step) begin
                r_x    <= w_next_x;
                r_y    <= w_next_y;
                r_addr <= w_next_addr;
            end
            if (w_load_first) begin
                r_write <= 1'b1;
                r_wdata <= r_colour;
            end else if (w_finish) begin
                r_write <= 1'b0;
            end
        end
    end

    // Read-back multiplexer reflecting the pre-edge register values
    always_comb begin
        w_rd_mux = '0;
        case (bus.ctrl_address)
            REG_BASE: w_rd_mux = r_base;
            REG_P0:   w_rd_mux = pack_point(r_p0);
            REG_P1:   w_rd_mux = pack_point(r_p1);
            REG_CMD:  w_rd_mux = pack_status(r_colour, r_irq_en, r_done, w_busy);
            default:  w_rd_mux = '0;
        endcase
    end

    // Registered read data; holds its value between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (bus.ctrl_read) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.ctrl_readdata         = r_readdata;
    assign bus.fill_master_address   = r_addr;
    assign bus.fill_master_write     = r_write;
    assign bus.fill_master_writedata = r_wdata;
    assign bus.irq                   = r_done & r_irq_en;
    assign o_dbg_state               = r_state;

endmodule

// File: tb/tb_pixel_rect_fill.sv
// Directed bench for pixel_rect_fill: register programming, fills with and
// without stalls, clipping, rejected rectangles, busy write masking and
// reset during a fill.
module tb_pixel_rect_fill;
  import pixel_fill_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  state_t dbg_state;

  pixel_rect_fill_if bus();

  pixel_rect_fill dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // scoreboard expected queues
  logic [31:0] exp_q[$];
  logic [15:0] exp_d_q[$];

  // captured accepted writes (monitor is the only writer)
  logic [31:0] got_addr_q[$];
  logic [15:0] got_data_q[$];
  int wr_cycles = 0;
  int stall_err = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  // monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (prev_stall && (bus.fill_master_write !== 1'b1 ||
                       bus.fill_master_address !== prev_addr ||
                       bus.fill_master_writedata !== prev_data))
      stall_err++;
    if (bus.fill_master_write === 1'b1) begin
      wr_cycles++;
      if (bus.fill_master_waitrequest === 1'b0) begin
        got_addr_q.push_back(bus.fill_master_address);
        got_data_q.push_back(bus.fill_master_writedata);
      end
    end
    prev_stall = (bus.fill_master_write === 1'b1) && (bus.fill_master_waitrequest === 1'b1);
    prev_addr  = bus.fill_master_address;
    prev_data  = bus.fill_master_writedata;
  end

  // driver: one control write, starts and ends at posedge+1
  task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
    bus.ctrl_address = a;
    bus.ctrl_writedata = d;
    bus.ctrl_write = 1'b1;
    @(posedge clk); #1;
    bus.ctrl_write = 1'b0;
  endtask

  // driver: one control read, data registered on the strobe edge
  task automatic ctrl_rd(input logic [1:0] a, output logic [31:0] d);
    bus.ctrl_address = a;
    bus.ctrl_read = 1'b1;
    @(posedge clk); #1;
    bus.ctrl_read = 1'b0;
    d = bus.ctrl_readdata;
  endtask

  // driver: run cycles (optionally with random stalls) until the engine idles
  task automatic wait_idle(input bit rand_stall, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.fill_master_waitrequest = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (dbg_state == IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    bus.fill_master_waitrequest = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
    n_checks++; if (bus.fill_master_write !== 1'b0) $display("FAIL reset_write: got %0b want 0", bus.fill_master_write); else n_pass++;
    n_checks++; if (bus.fill_master_address !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.fill_master_address); else n_pass++;
    n_checks++; if (bus.fill_master_writedata !== 16'h0) $display("FAIL reset_wdata: got %h want 0", bus.fill_master_writedata); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL reset_irq: got %0b want 0", bus.irq); else n_pass++;
    n_checks++; if (bus.ctrl_readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", bus.ctrl_readdata); else n_pass++;
    for (int r = 0; r < 4; r++) begin
      ctrl_rd(2'(r), rd);
      n_checks++; if (rd !== 32'h0) $display("FAIL reset_reg%0d: got %h want 0", r, rd); else n_pass++;
    end
  endtask

  task automatic test_basic;
    logic [31:0] rd;
    bit ok;
    int idx, c0, n;
    ctrl_wr(REG_BASE, 32'h0800_0000);
    ctrl_wr(REG_P0, 32'h0000_0000);
    ctrl_wr(REG_P1, 32'h0001_0001);
    idx = got_addr_q.size();
    c0 = wr_cycles;
    ctrl_wr(REG_CMD, 32'h0000_F800);
    n_checks++; if (dbg_state !== CLIP) $display("FAIL basic_clip_state: got %0d want %0d", dbg_state, CLIP); else n_pass++;
    n_checks++; if (bus.fill_master_write !== 1'b0) $display("FAIL basic_no_early_write: got %0b want 0", bus.fill_master_write); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.fill_master_write !== 1'b1) $display("FAIL basic_first_write: got %0b want 1", bus.fill_master_write); else n_pass++;
    n_checks++; if (bus.fill_master_address !== 32'h0800_0000) $display("FAIL basic_first_addr: got %h want 08000000", bus.fill_master_address); else n_pass++;
    wait_idle(1'b0, ok);
    n_checks++; if (!ok) $display("FAIL basic_timeout: got busy want idle"); else n_pass++;
    n_checks++; if (bus.fill_master_write !== 1'b0) $display("FAIL basic_write_drop: got %0b want 0", bus.fill_master_write); else n_pass++;
    n_checks++; if (wr_cycles - c0 !== 4) $display("FAIL basic_write_cycles: got %0d want 4", wr_cycles - c0); else n_pass++;
    exp_q = '{32'h0800_0000, 32'h0800_0002, 32'h0800_0400, 32'h0800_0402};
    n = got_addr_q.size() - idx;
    n_checks++; if (n !== 4) $display("FAIL basic_count: got %0d want 4", n); else n_pass++;
    for (int i = 0; i < 4 && i < n; i++) begin
      n_checks++; if (got_addr_q[idx+i] !== exp_q[i]) $display("FAIL basic_addr%0d: got %h want %h", i, got_addr_q[idx+i], exp_q[i]); else n_pass++;
      n_checks++; if (got_data_q[idx+i] !== 16'hF800) $display("FAIL basic_data%0d: got %h want f800", i, got_data_q[idx+i]); else n_pass++;
    end
    ctrl_rd(REG_CMD, rd);
    n_checks++; if (rd !== 32'hF800_0002) $display("FAIL basic_status: got %h want f8000002", rd); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL basic_irq: got %0b want 0", bus.irq); else n_pass++;
    ctrl_rd(REG_P1, rd);
    n_checks++; if (rd !== 32'h0001_0001) $display("FAIL basic_p1_readback: got %h want 00010001", rd); else n_pass++;
  endtask

  task automatic test_stall;
    bit ok;
    int idx, s0, n;
    idx = got_addr_q.size();
    s0 = stall_err;
    ctrl_wr(REG_CMD, 32'h0000_F800);
    wait_idle(1'b1, ok);
    n_checks++; if (!ok) $display("FAIL stall_timeout: got busy want idle"); else n_pass++;
    exp_q = '{32'h0800_0000, 32'h0800_0002, 32'h0800_0400, 32'h0800_0402};
    n = got_addr_q.size() - idx;
    n_checks++; if (n !== 4) $display("FAIL stall_count: got %0d want 4", n); else n_pass++;
    for (int i = 0; i < 4 && i < n; i++) begin
      n_checks++; if (got_addr_q[idx+i] !== exp_q[i] || got_data_q[idx+i] !== 16'hF800)
        $display("FAIL stall_write%0d: got %h/%h want %h/f800", i, got_addr_q[idx+i], got_data_q[idx+i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (stall_err - s0 !== 0) $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_err - s0); else n_pass++;
  endtask

  task automatic test_clamp;
    logic [31:0] rd;
    bit ok;
    int idx, n;
    ctrl_wr(REG_P0, 32'h00EF_013E);
    ctrl_wr(REG_P1, 32'h012C_0190);
    idx = got_addr_q.size();
    ctrl_wr(REG_CMD, 32'h0000_ABCD);
    wait_idle(1'b0, ok);
    n_checks++; if (!ok) $display("FAIL clamp_timeout: got busy want idle"); else n_pass++;
    exp_q = '{32'h0803_BE7C, 32'h0803_BE7E};
    n = got_addr_q.size() - idx;
    n_checks++; if (n !== 2) $display("FAIL clamp_count: got %0d want 2", n); else n_pass++;
    for (int i = 0; i < 2 && i < n; i++) begin
      n_checks++; if (got_addr_q[idx+i] !== exp_q[i] || got_data_q[idx+i] !== 16'hABCD)
        $display("FAIL clamp_write%0d: got %h/%h want %h/abcd", i, got_addr_q[idx+i], got_data_q[idx+i], exp_q[i]); else n_pass++;
    end
    ctrl_rd(REG_P1, rd);
    n_checks++; if (rd !== 32'h012C_0190) $display("FAIL clamp_p1_readback: got %h want 012c0190", rd); else n_pass++;
  endtask

  task automatic test_reject;
    logic [31:0] rd;
    int idx, c0;
    ctrl_wr(REG_P0, 32'h0005_000A);
    ctrl_wr(REG_P1, 32'h0005_0009);
    idx = got_addr_q.size();
    c0 = wr_cycles;
    ctrl_wr(REG_CMD, 32'h8000_1234);
    n_checks++; if (dbg_state !== CLIP) $display("FAIL reject_clip_state: got %0d want %0d", dbg_state, CLIP); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL reject_irq_cleared: got %0b want 0", bus.irq); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reject_idle: got %0d want 0", dbg_state); else n_pass++;
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL reject_irq: got %0b want 1", bus.irq); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wr_cycles - c0 !== 0 || got_addr_q.size() - idx !== 0)
      $display("FAIL reject_no_write: got %0d write cycles want 0", wr_cycles - c0); else n_pass++;
    ctrl_rd(REG_CMD, rd);
    n_checks++; if (rd !== 32'h1234_0006) $display("FAIL reject_status: got %h want 12340006", rd); else n_pass++;
  endtask

  task automatic test_busy_ignore;
    logic [31:0] rd;
    bit ok;
    int idx, n;
    ctrl_wr(REG_P0, 32'h0000_0000);
    ctrl_wr(REG_P1, 32'h0003_0003);
    idx = got_addr_q.size();
    ctrl_wr(REG_CMD, 32'h0000_07E0);
    ctrl_wr(REG_P0, 32'h0001_0001);
    ctrl_wr(REG_CMD, 32'h0000_001F);
    ctrl_wr(REG_BASE, 32'h1000_0000);
    wait_idle(1'b0, ok);
    n_checks++; if (!ok) $display("FAIL busy_timeout: got busy want idle"); else n_pass++;
    exp_q.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        exp_q.push_back(32'h0800_0000 + 32'(y * 1024) + 32'(x * 2));
    n = got_addr_q.size() - idx;
    n_checks++; if (n !== 16) $display("FAIL busy_count: got %0d want 16", n); else n_pass++;
    for (int i = 0; i < 16 && i < n; i++) begin
      n_checks++; if (got_addr_q[idx+i] !== exp_q[i] || got_data_q[idx+i] !== 16'h07E0)
        $display("FAIL busy_write%0d: got %h/%h want %h/07e0", i, got_addr_q[idx+i], got_data_q[idx+i], exp_q[i]); else n_pass++;
    end
    ctrl_rd(REG_P0, rd);
    n_checks++; if (rd !== 32'h0) $display("FAIL busy_p0_kept: got %h want 0", rd); else n_pass++;
    ctrl_rd(REG_BASE, rd);
    n_checks++; if (rd !== 32'h0800_0000) $display("FAIL busy_base_kept: got %h want 08000000", rd); else n_pass++;
    ctrl_rd(REG_CMD, rd);
    n_checks++; if (rd !== 32'h07E0_0002) $display("FAIL busy_status: got %h want 07e00002", rd); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bit ok;
    int idx, c0;
    idx = got_addr_q.size();
    c0 = wr_cycles;
    ctrl_wr(REG_CMD, 32'h8000_001F);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (got_addr_q.size() - idx >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("FAIL rstmid_timeout: got %0d writes want 3", got_addr_q.size() - idx); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.fill_master_write !== 1'b0) $display("FAIL rstmid_write: got %0b want 0", bus.fill_master_write); else n_pass++;
    n_checks++; if (bus.fill_master_address !== 32'h0 || bus.fill_master_writedata !== 16'h0)
      $display("FAIL rstmid_outputs: got %h/%h want 0/0", bus.fill_master_address, bus.fill_master_writedata); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL rstmid_state: got %0d want 0", dbg_state); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      ctrl_rd(2'(r), rd);
      n_checks++; if (rd !== 32'h0) $display("FAIL rstmid_reg%0d: got %h want 0", r, rd); else n_pass++;
    end
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL rstmid_irq: got %0b want 0", bus.irq); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (got_addr_q.size() - idx !== 3 || wr_cycles - c0 !== 3)
      $display("FAIL rstmid_activity: got %0d writes %0d cycles want 3 3", got_addr_q.size() - idx, wr_cycles - c0); else n_pass++;
  endtask

  initial begin
    bus.ctrl_address = '0;
    bus.ctrl_read = 1'b0;
    bus.ctrl_write = 1'b0;
    bus.ctrl_writedata = '0;
    bus.fill_master_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_clamp();
    test_reject();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
